// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, dmem waits.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance counters.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             mem_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
`endif
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LU    = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);
    localparam bit         FL_MULTI = (FLUSH_CYCLES > 1);

    state_e     state_q, state_d;
    logic [2:0] fl_cnt_q, fl_cnt_d;
    logic [7:0] wt_cnt_q, wt_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic       freeze;
    logic       timeout;
    logic       lu_haz;
    logic       frz_act;
    logic       fl_load;
    logic       fl_dec;
    logic       fl_clr;
    logic       pc_w;
    logic       ifid_w;
    logic       ifid_f;
    logic       idex_w;
    logic       idex_b;
    logic       exmem_w;
    logic       memwb_w;

    // Hazard conditions seen this cycle; XZR never carries a dependency.
    always_comb begin
        freeze  = dmem_req & ~dmem_ready;
        timeout = (state_q == WAIT) & freeze & (wt_cnt_q >= TMO);
        lu_haz  = id_valid & ex_memread & (ex_rd != 5'd31)
                & ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
    end

    // Priority: timeout, freeze, branch, then per-state behaviour.
    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        frz_act   = 1'b0;
        fl_load   = 1'b0;
        fl_dec    = 1'b0;
        fl_clr    = 1'b0;
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_f    = 1'b0;
        idex_w    = 1'b1;
        idex_b    = 1'b0;
        exmem_w   = 1'b1;
        memwb_w   = 1'b1;
        if (timeout) begin
            mem_err_d = 1'b1;
            fl_clr    = 1'b1;
            state_d   = RUN;
        end else if (freeze) begin
            frz_act = 1'b1;
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            memwb_w = 1'b0;
            state_d = WAIT;
        end else if (br_taken) begin
            ifid_f = 1'b1;
            if (FL_MULTI) begin
                fl_load = 1'b1;
                state_d = FLUSH;
            end else begin
                fl_clr  = 1'b1;
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (lu_haz) begin
                        pc_w    = 1'b0;
                        ifid_w  = 1'b0;
                        idex_b  = 1'b1;
                        state_d = LU;
                    end
                end
                LU: begin
                    state_d = RUN;
                end
                WAIT: begin
                    state_d = (fl_cnt_q != 3'd0) ? FLUSH : RUN;
                end
                FLUSH: begin
                    ifid_f  = 1'b1;
                    fl_dec  = 1'b1;
                    state_d = (fl_cnt_q <= 3'd1) ? RUN : FLUSH;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Flush counter: load on branch, count down in FLUSH, hold across waits.
    always_comb begin
        fl_cnt_d = fl_cnt_q;
        if (fl_clr) begin
            fl_cnt_d = 3'd0;
        end else if (fl_load) begin
            fl_cnt_d = FL_LOAD;
        end else if (fl_dec && (fl_cnt_q != 3'd0)) begin
            fl_cnt_d = fl_cnt_q - 3'd1;
        end
    end

    // Wait counter: number of frozen cycles in the current wait, saturating.
    always_comb begin
        wt_cnt_d = 8'd0;
        if (frz_act) begin
            if (state_q != WAIT) begin
                wt_cnt_d = 8'd1;
            end else if (wt_cnt_q != 8'hFF) begin
                wt_cnt_d = wt_cnt_q + 8'd1;
            end else begin
                wt_cnt_d = wt_cnt_q;
            end
        end
    end

    // Sequencing state and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            fl_cnt_q  <= 3'd0;
            wt_cnt_q  <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fl_cnt_q  <= fl_cnt_d;
            wt_cnt_q  <= wt_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Enables are held low for as long as reset is asserted.
    always_comb begin
        pc_write    = reset_n & pc_w;
        ifid_write  = reset_n & ifid_w;
        ifid_flush  = reset_n & ifid_f;
        idex_write  = reset_n & idex_w;
        idex_bubble = reset_n & idex_b;
        exmem_write = reset_n & exmem_w;
        memwb_write = reset_n & memwb_w;
        mem_err     = mem_err_q;
        state_o     = state_q;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] fls_cnt_q, fls_cnt_d;
    logic [CNT_W-1:0] frz_cnt_q, frz_cnt_d;

    // Saturating event counts for bubbles, flushes and frozen cycles.
    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        fls_cnt_d = fls_cnt_q;
        frz_cnt_d = frz_cnt_q;
        if (idex_b && (lu_cnt_q != '1)) begin
            lu_cnt_d = lu_cnt_q + 1'b1;
        end
        if (ifid_f && (fls_cnt_q != '1)) begin
            fls_cnt_d = fls_cnt_q + 1'b1;
        end
        if (frz_act && (frz_cnt_q != '1)) begin
            frz_cnt_d = frz_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lu_cnt_q  <= '0;
            fls_cnt_q <= '0;
            frz_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            fls_cnt_q <= fls_cnt_d;
            frz_cnt_q <= frz_cnt_d;
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign flush_cnt    = fls_cnt_q;
    assign wait_cnt     = frz_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=8).
// Directed steps followed by random traffic against an event-level model.
module tb_hazard_stall_ctrl;

    localparam int FC  = 3;
    localparam int TMO = 8;
    localparam int CW  = 16;

    localparam int EV_RST   = 0;
    localparam int EV_EXP   = 1;
    localparam int EV_STALL = 2;
    localparam int EV_BR    = 3;
    localparam int EV_REL   = 4;
    localparam int EV_FL    = 5;
    localparam int EV_LU    = 6;
    localparam int EV_IDLE  = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_uses_rm;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       br_taken;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_bubble;
    logic       exmem_write;
    logic       memwb_write;
    logic       mem_err;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] lu_stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] wait_cnt;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .id_valid   (id_valid),
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_uses_rm (id_uses_rm),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .br_taken   (br_taken),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .ifid_flush (ifid_flush),
        .idex_write (idex_write),
        .idex_bubble(idex_bubble),
        .exmem_write(exmem_write),
        .memwb_write(memwb_write),
        .mem_err    (mem_err),
`ifdef HAZARD_PERF_CNT_EN
        .lu_stall_cnt(lu_stall_cnt),
        .flush_cnt  (flush_cnt),
        .wait_cnt   (wait_cnt),
`endif
        .state_o    (state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fl_seen = 0;
    int frz_seen = 0;

    // Model: frozen cycles so far, flush cycles still owed, one-cycle
    // load-use shadow, sticky error, and event totals.
    int frozen_for = 0;
    int flush_left = 0;
    bit lu_shadow = 1'b0;
    bit err_m = 1'b0;
    int n_lu = 0;
    int n_fl = 0;
    int n_wt = 0;

    function automatic bit hazard();
        return id_valid && ex_memread && (ex_rd != 5'd31)
            && ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    endfunction

    function automatic int classify();
        bit stall = dmem_req && !dmem_ready;
        if (!reset_n) return EV_RST;
        if (stall && frozen_for >= TMO) return EV_EXP;
        if (stall) return EV_STALL;
        if (br_taken) return EV_BR;
        if (frozen_for > 0) return EV_REL;
        if (flush_left > 0) return EV_FL;
        if (!lu_shadow && hazard()) return EV_LU;
        return EV_IDLE;
    endfunction

    // Enable bundle: {pc, ifid_w, ifid_flush, idex_w, idex_bubble, exmem, memwb}
    function automatic logic [6:0] exp_en(input int ev);
        case (ev)
            EV_RST, EV_STALL: return 7'b0000000;
            EV_BR, EV_FL:     return 7'b1111011;
            EV_LU:            return 7'b0001111;
            default:          return 7'b1101011;
        endcase
    endfunction

    function automatic logic [1:0] exp_st();
        if (!reset_n) return 2'd0;
        if (frozen_for > 0) return 2'd2;
        if (flush_left > 0) return 2'd3;
        if (lu_shadow) return 2'd1;
        return 2'd0;
    endfunction

    task automatic upd(input int ev);
        case (ev)
            EV_RST: begin
                frozen_for = 0; flush_left = 0; lu_shadow = 0; err_m = 0;
                n_lu = 0; n_fl = 0; n_wt = 0;
            end
            EV_EXP: begin
                err_m = 1; frozen_for = 0; flush_left = 0; lu_shadow = 0;
            end
            EV_STALL: begin
                frozen_for = (frozen_for == 0) ? 1
                           : ((frozen_for < 255) ? frozen_for + 1 : 255);
                lu_shadow = 0;
                n_wt++;
            end
            EV_BR: begin
                flush_left = FC - 1; frozen_for = 0; lu_shadow = 0;
                n_fl++;
            end
            EV_REL: begin
                frozen_for = 0; lu_shadow = 0;
            end
            EV_FL: begin
                flush_left--;
                n_fl++;
            end
            EV_LU: begin
                lu_shadow = 1;
                n_lu++;
            end
            default: lu_shadow = 0;
        endcase
    endtask

    task automatic chk(input string tag);
        int         ev;
        logic [6:0] obs;
        logic [6:0] want;
        logic       werr;
        ev   = classify();
        want = exp_en(ev);
        werr = reset_n ? err_m : 1'b0;
        obs  = {pc_write, ifid_write, ifid_flush, idex_write,
                idex_bubble, exmem_write, memwb_write};
        if (ifid_flush === 1'b1) fl_seen++;
        if (reset_n && obs === 7'b0000000) frz_seen++;
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s enables obs=%b exp=%b", tag, obs, want);
        end
        n_cmp++;
        assert (mem_err === werr) else begin
            n_bad++;
            $error("FAIL %s mem_err obs=%b exp=%b", tag, mem_err, werr);
        end
        n_cmp++;
        assert (state_o === exp_st()) else begin
            n_bad++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, state_o, exp_st());
        end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        assert (lu_stall_cnt === CW'(n_lu) && flush_cnt === CW'(n_fl)
                && wait_cnt === CW'(n_wt)) else begin
            n_bad++;
            $error("FAIL %s perf obs=%0d/%0d/%0d exp=%0d/%0d/%0d", tag,
                   lu_stall_cnt, flush_cnt, wait_cnt, n_lu, n_fl, n_wt);
        end
`endif
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        chk(tag);
        @(posedge clk);
        upd(classify());
        #1;
    endtask

    task automatic cc(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, want);
        end
    endtask

    task automatic quiet();
        id_valid = 0; id_rn = 0; id_rm = 0; id_uses_rm = 0;
        ex_memread = 0; ex_rd = 0; br_taken = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    int stuck = 0;

    initial begin
        quiet();
        reset_n = 1'b0;
        #12;
        cc("rst_pc", 32'(pc_write), 0);
        cc("rst_st", 32'(state_o), 0);
        cyc("rst");
        cyc("rst");
        reset_n = 1'b1;
        cyc("idle");
        cyc("idle");
        #1;
        cc("idle_pc", 32'(pc_write), 1);

        // Load-use on Rn: one bubble, then LU, then RUN
        id_valid = 1; ex_memread = 1; ex_rd = 5; id_rn = 5;
        #1;
        cc("lu_bub", 32'(idex_bubble), 1);
        cc("lu_pc", 32'(pc_write), 0);
        cyc("lu_stall");
        ex_memread = 0;
        #1;
        cc("lu_st", 32'(state_o), 1);
        cyc("lu_state");
        #1;
        cc("lu_back", 32'(state_o), 0);
        cyc("lu_run");

        // Load-use on Rm with the same instruction not reading Rm
        ex_memread = 1; ex_rd = 9; id_rn = 1; id_rm = 9; id_uses_rm = 0;
        cyc("rm_unused");
        id_uses_rm = 1;
        cyc("rm_used");
        ex_memread = 0;
        cyc("rm_after");

        // XZR destination never stalls
        ex_memread = 1; ex_rd = 31; id_rn = 31;
        #1;
        cc("xzr_pc", 32'(pc_write), 1);
        cyc("xzr");
        quiet();

        // Branch overrides load-use; flush spans three cycles
        id_valid = 1; ex_memread = 1; ex_rd = 7; id_rn = 7; br_taken = 1;
        #1;
        cc("br_fl", 32'(ifid_flush), 1);
        cc("br_bub", 32'(idex_bubble), 0);
        fl_seen = 0;
        cyc("br");
        quiet();
        cyc("fl1");
        cyc("fl2");
        cyc("fl3");
        cc("fl_len", 32'(fl_seen), 3);

        // Four frozen cycles, then ready
        frz_seen = 0;
        dmem_req = 1;
        repeat (4) cyc("wait");
        dmem_ready = 1;
        #1;
        cc("rdy_pc", 32'(pc_write), 1);
        cc("rdy_mw", 32'(memwb_write), 1);
        cyc("ready");
        quiet();
        cyc("post");
        cc("frz_len", 32'(frz_seen), 4);
`ifdef HAZARD_PERF_CNT_EN
        cc("wait_cnt", 32'(wait_cnt), 4);
`endif

        // Freeze during FLUSH: flush resumes after the wait
        br_taken = 1;
        cyc("br2");
        br_taken = 0; dmem_req = 1;
        cyc("fl_frz");
        cyc("fl_frz2");
        dmem_ready = 1;
        cyc("fl_rel");
        quiet();
        #1;
        cc("fl_resume", 32'(state_o), 3);
        cyc("fl_res1");
        cyc("fl_res2");

        // Timeout: eight frozen cycles then mem_err
        dmem_req = 1;
        repeat (TMO) cyc("tmo_wait");
        #1;
        cc("tmo_rel", 32'(pc_write), 1);
        cyc("tmo");
        #1;
        cc("tmo_err", 32'(mem_err), 1);
        cc("tmo_st", 32'(state_o), 0);
        dmem_req = 0;
        cyc("tmo_after");
        cyc("tmo_after");
        cc("err_stk", 32'(mem_err), 1);

        // Reset in the middle of a wait
        dmem_req = 1;
        cyc("w_pre");
        cyc("w_pre");
        reset_n = 0;
        #1;
        cc("rw_st", 32'(state_o), 0);
        cc("rw_pc", 32'(pc_write), 0);
        cc("rw_err", 32'(mem_err), 0);
        cyc("rst_w");
        quiet();
        reset_n = 1;
        cyc("rw_idle");

        // Reset in the middle of a flush
        br_taken = 1;
        cyc("br3");
        br_taken = 0;
        #1;
        cc("rf_pre", 32'(state_o), 3);
        reset_n = 0;
        #1;
        cc("rf_st", 32'(state_o), 0);
        cc("rf_fl", 32'(ifid_flush), 0);
        cyc("rst_f");
        reset_n = 1;
        cyc("rf_idle");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (stuck > 0) begin
                dmem_req = 1; dmem_ready = 0;
                stuck--;
            end else begin
                if ($urandom_range(0, 99) < 4) stuck = $urandom_range(3, 12);
                dmem_req   = ($urandom_range(0, 99) < 25);
                dmem_ready = ($urandom_range(0, 99) < 50);
            end
            br_taken   = ($urandom_range(0, 99) < 12);
            id_valid   = ($urandom_range(0, 99) < 85);
            ex_memread = ($urandom_range(0, 99) < 40);
            id_uses_rm = ($urandom_range(0, 1) == 1);
            ex_rd = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_rn = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_rm = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            reset_n = ($urandom_range(0, 499) != 0);
            cyc("rand");
        end
        reset_n = 1;
        quiet();
        cyc("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
